// File: rtl/apu_reg_pkg.sv
// Register map and read masks shared by the APU channel register front ends.
// A read returns the stored bits OR'd with the channel's read mask.
package apu_reg_pkg;

    localparam logic [7:0] NR30_A    = 8'h1A;
    localparam logic [7:0] NR31_A    = 8'h1B;
    localparam logic [7:0] NR32_A    = 8'h1C;
    localparam logic [7:0] NR33_A    = 8'h1D;
    localparam logic [7:0] NR34_A    = 8'h1E;
    localparam logic [7:0] WAVE_BASE = 8'h30;
    localparam logic [7:0] WAVE_LAST = 8'h3F;

    // Set bits read back as 1 regardless of the stored value.
    localparam logic [7:0] NR30_RMASK = 8'h7F;
    localparam logic [7:0] NR31_RMASK = 8'hFF;
    localparam logic [7:0] NR32_RMASK = 8'h9F;
    localparam logic [7:0] NR33_RMASK = 8'hFF;
    localparam logic [7:0] NR34_RMASK = 8'hBF;

    function automatic logic [7:0] masked_read(input logic [7:0] raw, input logic [7:0] rmask);
        return raw | rmask;
    endfunction

endpackage

// File: rtl/wave_ram.sv
// 16x8 wave sample RAM: synchronous write, registered read, reset fill, and the
// nibble-unpacked view of all 32 samples.
module wave_ram #(
    parameter logic [7:0] RAM_RESET_VAL = 8'h00
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [3:0]   waddr,
    input  logic [7:0]   wdata,
    input  logic         rd_en,
    input  logic [3:0]   raddr,
    output logic [7:0]   rdata,
    output logic [127:0] samples
);

    logic [7:0] mem_q [16];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= RAM_RESET_VAL;
            end
            rdata <= 8'h00;
        end else begin
            if (wr_en) begin
                mem_q[waddr] <= wdata;
            end
            // Same-edge read sees the pre-write byte.
            if (rd_en) begin
                rdata <= mem_q[raddr];
            end
        end
    end

    // Byte k: high nibble is sample 2k, low nibble is sample 2k+1.
    always_comb begin
        samples = '0;
        for (int k = 0; k < 16; k++) begin
            samples[8*k +: 4]     = mem_q[k][7:4];
            samples[8*k + 4 +: 4] = mem_q[k][3:0];
        end
    end

endmodule

// File: rtl/wave_reg_if.sv
// CPU register front end for the wave channel: NR30-NR34 control state, wave RAM
// access, registered read-back and the one-cycle trigger / length-load strobes.
module wave_reg_if
    import apu_reg_pkg::*;
#(
    parameter int unsigned ADDR_W        = 8,
    parameter logic [7:0]  RAM_RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              apu_on,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              dac_enable,
    output logic [1:0]        vol,
    output logic [7:0]        len_load,
    output logic              len_load_strobe,
    output logic              trigger,
    output logic              len_enable,
    output logic [10:0]       freq,
    output logic [127:0]      samples
);

    logic        dac_enable_q;
    logic [1:0]  vol_q;
    logic [7:0]  len_load_q;
    logic        len_load_strobe_q;
    logic        trigger_q;
    logic        len_enable_q;
    logic [10:0] freq_q;
    logic [7:0]  reg_rdata_q;
    logic        rd_ram_q;

    logic        is_wave;
    logic [7:0]  reg_rd_val;
    logic [7:0]  ram_rdata;

    assign is_wave = (addr >= ADDR_W'(WAVE_BASE)) && (addr <= ADDR_W'(WAVE_LAST));

    // Powered-off state reads as cleared even in the cycle before the clear lands.
    always_comb begin
        logic       dac_v;
        logic [1:0] vol_v;
        logic       len_en_v;
        dac_v      = dac_enable_q & apu_on;
        vol_v      = vol_q & {2{apu_on}};
        len_en_v   = len_enable_q & apu_on;
        reg_rd_val = 8'hFF;
        case (addr)
            ADDR_W'(NR30_A): reg_rd_val = masked_read({dac_v, 7'h00}, NR30_RMASK);
            ADDR_W'(NR31_A): reg_rd_val = masked_read(8'h00, NR31_RMASK);
            ADDR_W'(NR32_A): reg_rd_val = masked_read({1'b0, vol_v, 5'h00}, NR32_RMASK);
            ADDR_W'(NR33_A): reg_rd_val = masked_read(8'h00, NR33_RMASK);
            ADDR_W'(NR34_A): reg_rd_val = masked_read({1'b0, len_en_v, 6'h00}, NR34_RMASK);
            default:         reg_rd_val = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dac_enable_q      <= 1'b0;
            vol_q             <= 2'd0;
            len_load_q        <= 8'h00;
            len_load_strobe_q <= 1'b0;
            trigger_q         <= 1'b0;
            len_enable_q      <= 1'b0;
            freq_q            <= 11'd0;
            reg_rdata_q       <= 8'hFF;
            rd_ram_q          <= 1'b0;
        end else begin
            trigger_q         <= 1'b0;
            len_load_strobe_q <= 1'b0;
            if (!apu_on) begin
                dac_enable_q <= 1'b0;
                vol_q        <= 2'd0;
                len_load_q   <= 8'h00;
                len_enable_q <= 1'b0;
                freq_q       <= 11'd0;
            end else if (wr_en) begin
                case (addr)
                    ADDR_W'(NR30_A): dac_enable_q <= wdata[7];
                    ADDR_W'(NR31_A): begin
                        len_load_q        <= wdata;
                        len_load_strobe_q <= 1'b1;
                    end
                    ADDR_W'(NR32_A): vol_q <= wdata[6:5];
                    ADDR_W'(NR33_A): freq_q[7:0] <= wdata;
                    ADDR_W'(NR34_A): begin
                        len_enable_q <= wdata[6];
                        freq_q[10:8] <= wdata[2:0];
                        trigger_q    <= wdata[7];
                    end
                    default: ;
                endcase
            end
            if (rd_en) begin
                reg_rdata_q <= reg_rd_val;
                rd_ram_q    <= is_wave;
            end
        end
    end

    // WAVE_BASE is 16-aligned, so the low nibble of addr is the RAM index.
    wave_ram #(
        .RAM_RESET_VAL(RAM_RESET_VAL)
    ) u_wave_ram (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en && is_wave),
        .waddr  (addr[3:0]),
        .wdata  (wdata),
        .rd_en  (rd_en && is_wave),
        .raddr  (addr[3:0]),
        .rdata  (ram_rdata),
        .samples(samples)
    );

    assign rdata           = rd_ram_q ? ram_rdata : reg_rdata_q;
    assign dac_enable      = dac_enable_q;
    assign vol             = vol_q;
    assign len_load        = len_load_q;
    assign len_load_strobe = len_load_strobe_q;
    assign trigger         = trigger_q;
    assign len_enable      = len_enable_q;
    assign freq            = freq_q;

endmodule

// File: tb/tb_wave_reg_if.sv
// Directed bench for wave_reg_if; read results are checked through an expected-value queue.
module tb_wave_reg_if;

    logic         clk = 1'b0;
    logic         reset;
    logic         apu_on;
    logic [7:0]   addr;
    logic         wr_en;
    logic         rd_en;
    logic [7:0]   wdata;
    logic [7:0]   rdata;
    logic         dac_enable;
    logic [1:0]   vol;
    logic [7:0]   len_load;
    logic         len_load_strobe;
    logic         trigger;
    logic         len_enable;
    logic [10:0]  freq;
    logic [127:0] samples;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    wave_reg_if #(
        .ADDR_W       (8),
        .RAM_RESET_VAL(8'h00)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .apu_on         (apu_on),
        .addr           (addr),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .wdata          (wdata),
        .rdata          (rdata),
        .dac_enable     (dac_enable),
        .vol            (vol),
        .len_load       (len_load),
        .len_load_strobe(len_load_strobe),
        .trigger        (trigger),
        .len_enable     (len_enable),
        .freq           (freq),
        .samples        (samples)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        rd_en = 1'b0;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {120'd0, rdata}, {120'd0, e});
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        addr  = a;
        rd_en = 1'b1;
        wr_en = 1'b0;
        exp_q.push_back(e);
        step();
        rd_en = 1'b0;
        pop_check($sformatf("rd_%02h", a));
    endtask

    task automatic check_ctrl_zero(input string tag);
        check({tag, "_dac"}, {127'd0, dac_enable}, 128'd0);
        check({tag, "_vol"}, {126'd0, vol}, 128'd0);
        check({tag, "_len_load"}, {120'd0, len_load}, 128'd0);
        check({tag, "_lls"}, {127'd0, len_load_strobe}, 128'd0);
        check({tag, "_trig"}, {127'd0, trigger}, 128'd0);
        check({tag, "_len_en"}, {127'd0, len_enable}, 128'd0);
        check({tag, "_freq"}, {117'd0, freq}, 128'd0);
    endtask

    initial begin
        reset  = 1'b1;
        apu_on = 1'b0;
        addr   = 8'h00;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        wdata  = 8'h00;
        step();
        step();
        reset = 1'b0;

        check("rst_rdata", {120'd0, rdata}, {120'd0, 8'hFF});
        check_ctrl_zero("rst");
        check("rst_samples", samples, 128'd0);

        rd(8'h1A, 8'h7F);
        rd(8'h1B, 8'hFF);
        rd(8'h1C, 8'h9F);
        rd(8'h1D, 8'hFF);
        rd(8'h1E, 8'hBF);
        rd(8'h30, 8'h00);
        rd(8'h20, 8'hFF);
        idle();
        check("rd_hold", {120'd0, rdata}, {120'd0, 8'hFF});

        apu_on = 1'b1;
        idle();
        check("pwr_on_trig", {127'd0, trigger}, 128'd0);
        check("pwr_on_lls", {127'd0, len_load_strobe}, 128'd0);

        wr(8'h1D, 8'h34);
        check("nr33_trig", {127'd0, trigger}, 128'd0);
        wr(8'h1E, 8'hC5);
        check("nr34_freq", {117'd0, freq}, {117'd0, 11'h534});
        check("nr34_len_en", {127'd0, len_enable}, 128'd1);
        check("nr34_trig", {127'd0, trigger}, 128'd1);
        idle();
        check("trig_one_cycle", {127'd0, trigger}, 128'd0);
        wr(8'h1E, 8'h45);
        check("nr34_notrig", {127'd0, trigger}, 128'd0);
        check("nr34_freq_keep", {117'd0, freq}, {117'd0, 11'h534});

        wr(8'h1E, 8'h85);
        check("b2b_trig0", {127'd0, trigger}, 128'd1);
        wr(8'h1E, 8'h85);
        check("b2b_trig1", {127'd0, trigger}, 128'd1);
        check("b2b_len_en", {127'd0, len_enable}, 128'd0);
        idle();
        check("b2b_trig_end", {127'd0, trigger}, 128'd0);

        wr(8'h1C, 8'h40);
        check("nr32_lls", {127'd0, len_load_strobe}, 128'd0);
        wr(8'h1A, 8'h80);
        wr(8'h1B, 8'hC0);
        check("vol", {126'd0, vol}, 128'd2);
        check("dac", {127'd0, dac_enable}, 128'd1);
        check("len_load", {120'd0, len_load}, {120'd0, 8'hC0});
        check("lls_pulse", {127'd0, len_load_strobe}, 128'd1);
        idle();
        check("lls_end", {127'd0, len_load_strobe}, 128'd0);
        rd(8'h1C, 8'hDF);
        rd(8'h1A, 8'hFF);
        rd(8'h1E, 8'hBF);
        rd(8'h1B, 8'hFF);

        wr(8'h30, 8'hA5);
        wr(8'h3F, 8'h0F);
        check("smp0", {124'd0, samples[3:0]}, 128'hA);
        check("smp1", {124'd0, samples[7:4]}, 128'h5);
        check("smp30", {124'd0, samples[123:120]}, 128'h0);
        check("smp31", {124'd0, samples[127:124]}, 128'hF);

        addr  = 8'h30;
        wdata = 8'h11;
        wr_en = 1'b1;
        rd_en = 1'b1;
        exp_q.push_back(8'hA5);
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        pop_check("rbw_30");
        rd(8'h30, 8'h11);
        rd(8'h3F, 8'h0F);

        wr(8'h20, 8'hFF);
        check("unmapped_vol", {126'd0, vol}, 128'd2);
        check("unmapped_freq", {117'd0, freq}, {117'd0, 11'h534});

        apu_on = 1'b0;
        idle();
        wr(8'h1E, 8'h87);
        check_ctrl_zero("off");
        rd(8'h1A, 8'h7F);
        rd(8'h1C, 8'h9F);
        wr(8'h31, 8'h3C);
        check("off_smp2", {124'd0, samples[11:8]}, 128'h3);
        check("off_smp3", {124'd0, samples[15:12]}, 128'hC);
        rd(8'h31, 8'h3C);
        check("off_smp0_kept", {124'd0, samples[3:0]}, 128'h1);

        apu_on = 1'b1;
        idle();
        check("pwr_on2_trig", {127'd0, trigger}, 128'd0);
        check("pwr_on2_freq", {117'd0, freq}, 128'd0);

        wr(8'h1E, 8'h80);
        check("pre_rst_trig", {127'd0, trigger}, 128'd1);
        // Reset coinciding with another trigger write: reset must win.
        reset = 1'b1;
        addr  = 8'h1E;
        wdata = 8'h83;
        wr_en = 1'b1;
        step();
        reset = 1'b0;
        wr_en = 1'b0;
        check("rst_trig", {127'd0, trigger}, 128'd0);
        check("rst_freq", {117'd0, freq}, 128'd0);
        check("rst_ram", samples, 128'd0);
        check("rst_rdata2", {120'd0, rdata}, {120'd0, 8'hFF});
        idle();
        check("rst_trig_after", {127'd0, trigger}, 128'd0);
        rd(8'h31, 8'h00);
        rd(8'h3F, 8'h00);

        check("sb_empty", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
